// File: rtl/cc_psr_branch_unit.sv
// Condition-code (PSR) register plus a one-entry branch resolver for the microsequencer.
// Flags written this cycle are forwarded into a branch evaluated in the same cycle.
module cc_psr_branch_unit #(
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_COND          = 4
) (
    input  logic                               CC_PSR_CLOCK_50,
    input  logic                               CC_PSR_RESET_InLow,
    input  logic                               CC_PSR_Negative_InHigh,
    input  logic                               CC_PSR_Zero_InHigh,
    input  logic                               CC_PSR_Overflow_InHigh,
    input  logic                               CC_PSR_Carry_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_PSR_ALUSelection_In,
    input  logic                               CC_PSR_Execute_InHigh,
    input  logic [DATAWIDTH_COND-1:0]          CC_PSR_Cond_In,
    input  logic                               CC_PSR_BranchReq_InHigh,
    input  logic                               CC_PSR_BranchAck_InHigh,
    output logic [3:0]                         CC_PSR_Flags_Out,
    output logic                               CC_PSR_BranchValid_OutHigh,
    output logic                               CC_PSR_BranchTaken_OutHigh,
    output logic                               CC_PSR_IllegalCond_OutHigh,
    output logic                               CC_PSR_Busy_OutHigh
);

    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ANDCC = DATAWIDTH_ALU_SELECTION'(0);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ORCC  = DATAWIDTH_ALU_SELECTION'(1);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_NORCC = DATAWIDTH_ALU_SELECTION'(2);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ADDCC = DATAWIDTH_ALU_SELECTION'(3);

    localparam logic [DATAWIDTH_COND-1:0] COND_BN   = DATAWIDTH_COND'(0);
    localparam logic [DATAWIDTH_COND-1:0] COND_BE   = DATAWIDTH_COND'(1);
    localparam logic [DATAWIDTH_COND-1:0] COND_BCS  = DATAWIDTH_COND'(5);
    localparam logic [DATAWIDTH_COND-1:0] COND_BNEG = DATAWIDTH_COND'(6);
    localparam logic [DATAWIDTH_COND-1:0] COND_BVS  = DATAWIDTH_COND'(7);
    localparam logic [DATAWIDTH_COND-1:0] COND_BA   = DATAWIDTH_COND'(8);

    typedef enum logic {IDLE, VALID} state_t;

    state_t     state, state_next;
    logic [3:0] flags, flags_next;
    logic       taken, taken_next;
    logic       illegal, illegal_next;
    logic       eval_taken, eval_illegal;

    // Logical ops only produce meaningful N/Z, so V/C are forced clear.
    always_comb begin
        flags_next = flags;
        if (CC_PSR_Execute_InHigh) begin
            if (CC_PSR_ALUSelection_In == SEL_ANDCC || CC_PSR_ALUSelection_In == SEL_ORCC ||
                CC_PSR_ALUSelection_In == SEL_NORCC)
                flags_next = {CC_PSR_Negative_InHigh, CC_PSR_Zero_InHigh, 2'b00};
            else if (CC_PSR_ALUSelection_In == SEL_ADDCC)
                flags_next = {CC_PSR_Negative_InHigh, CC_PSR_Zero_InHigh,
                              CC_PSR_Overflow_InHigh, CC_PSR_Carry_InHigh};
        end
    end

    // flags_next layout is {N,Z,V,C}
    always_comb begin
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
        case (CC_PSR_Cond_In)
            COND_BN:   eval_taken = 1'b0;
            COND_BE:   eval_taken = flags_next[2];
            COND_BCS:  eval_taken = flags_next[0];
            COND_BNEG: eval_taken = flags_next[3];
            COND_BVS:  eval_taken = flags_next[1];
            COND_BA:   eval_taken = 1'b1;
            default:   eval_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next   = state;
        taken_next   = taken;
        illegal_next = illegal;
        case (state)
            IDLE: begin
                if (CC_PSR_BranchReq_InHigh) begin
                    state_next   = VALID;
                    taken_next   = eval_taken;
                    illegal_next = eval_illegal;
                end
            end
            VALID: begin
                if (CC_PSR_BranchAck_InHigh) begin
                    if (CC_PSR_BranchReq_InHigh) begin
                        taken_next   = eval_taken;
                        illegal_next = eval_illegal;
                    end else begin
                        state_next   = IDLE;
                        taken_next   = 1'b0;
                        illegal_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                taken_next   = 1'b0;
                illegal_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            state   <= IDLE;
            flags   <= 4'b0000;
            taken   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            flags   <= flags_next;
            taken   <= taken_next;
            illegal <= illegal_next;
        end
    end

    assign CC_PSR_Flags_Out           = flags;
    assign CC_PSR_BranchValid_OutHigh = (state == VALID);
    assign CC_PSR_BranchTaken_OutHigh = taken;
    assign CC_PSR_IllegalCond_OutHigh = illegal;
    assign CC_PSR_Busy_OutHigh        = (state == VALID) & ~CC_PSR_BranchAck_InHigh;

endmodule

// File: tb/tb_cc_psr_branch_unit.sv
// Directed bench for cc_psr_branch_unit: a flag/handshake model feeds a result
// queue that is checked against the DUT every cycle, plus fixed-value checks.
module tb_cc_psr_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       n_in, z_in, v_in, c_in;
    logic [3:0] sel;
    logic       execute;
    logic [3:0] cond;
    logic       req, ack;
    logic [3:0] flags;
    logic       valid, taken, illegal, busy;

    int passed = 0;
    int total  = 0;

    logic [3:0] mflags;
    logic       mvalid;
    logic [1:0] sb[$];   // {taken, illegal} per accepted request

    always #5 clk = ~clk;

    cc_psr_branch_unit #(.DATAWIDTH_ALU_SELECTION(4), .DATAWIDTH_COND(4)) dut (
        .CC_PSR_CLOCK_50            (clk),
        .CC_PSR_RESET_InLow         (rst_n),
        .CC_PSR_Negative_InHigh     (n_in),
        .CC_PSR_Zero_InHigh         (z_in),
        .CC_PSR_Overflow_InHigh     (v_in),
        .CC_PSR_Carry_InHigh        (c_in),
        .CC_PSR_ALUSelection_In     (sel),
        .CC_PSR_Execute_InHigh      (execute),
        .CC_PSR_Cond_In             (cond),
        .CC_PSR_BranchReq_InHigh    (req),
        .CC_PSR_BranchAck_InHigh    (ack),
        .CC_PSR_Flags_Out           (flags),
        .CC_PSR_BranchValid_OutHigh (valid),
        .CC_PSR_BranchTaken_OutHigh (taken),
        .CC_PSR_IllegalCond_OutHigh (illegal),
        .CC_PSR_Busy_OutHigh        (busy)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] mflag_next(input logic [3:0] f);
        if (execute && sel <= 4'd2) return {n_in, z_in, 2'b00};
        if (execute && sel == 4'd3) return {n_in, z_in, v_in, c_in};
        return f;
    endfunction

    function automatic logic [1:0] meval(input logic [3:0] c, input logic [3:0] f);
        case (c)
            4'd0:    return 2'b00;
            4'd1:    return {f[2], 1'b0};
            4'd5:    return {f[0], 1'b0};
            4'd6:    return {f[3], 1'b0};
            4'd7:    return {f[1], 1'b0};
            4'd8:    return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic drive(input logic ex, input logic [3:0] s, input logic [3:0] nzvc,
                         input logic r, input logic [3:0] cd, input logic a);
        execute = ex; sel = s;
        {n_in, z_in, v_in, c_in} = nzvc;
        req = r; cond = cd; ack = a;
    endtask

    // One clock: update the model from the inputs in force, then check the DUT after the edge.
    task automatic cyc(input string tag);
        logic [3:0] fn;
        fn = mflag_next(mflags);
        if (mvalid && ack) begin
            void'(sb.pop_front());
            if (req) sb.push_back(meval(cond, fn));
            else mvalid = 1'b0;
        end else if (!mvalid && req) begin
            sb.push_back(meval(cond, fn));
            mvalid = 1'b1;
        end
        mflags = fn;
        @(posedge clk);
        #1;
        chk({tag, ".flags"}, flags, mflags);
        chk({tag, ".valid"}, {3'b0, valid}, {3'b0, mvalid});
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, mvalid & ~ack});
        if (mvalid && sb.size() > 0)
            chk({tag, ".result"}, {2'b0, taken, illegal}, {2'b0, sb[0]});
        else
            chk({tag, ".idle_result"}, {2'b0, taken, illegal}, 4'b0000);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 0);
        mflags = 4'b0000;
        mvalid = 1'b0;
        #1;
        chk("rst.flags", flags, 4'b0000);
        chk("rst.outs", {valid, taken, illegal, busy}, 4'b0000);
        #11 rst_n = 1'b1;

        // T2: ADDCC 0x7FFFFFFF+1 -> N=1,V=1, then bvs
        drive(1, 4'd3, 4'b1010, 0, 4'd0, 0); cyc("t2.add");
        chk("t2.flags1010", flags, 4'b1010);
        drive(0, 4'd0, 4'b0000, 1, 4'd7, 0); cyc("t2.bvs");
        chk("t2.bvs_taken", {2'b0, valid, taken}, 4'b0011);
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 1); cyc("t2.ack");

        // T3: ANDCC clears V,C even when the ALU drives them high
        drive(1, 4'd0, 4'b0111, 0, 4'd0, 0); cyc("t3.and");
        chk("t3.flags0100", flags, 4'b0100);
        drive(0, 4'd0, 4'b0000, 1, 4'd5, 0); cyc("t3.bcs");
        chk("t3.bcs_taken", {3'b0, taken}, 4'b0000);
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 1); cyc("t3.ack1");
        drive(0, 4'd0, 4'b0000, 1, 4'd1, 0); cyc("t3.be");
        chk("t3.be_taken", {3'b0, taken}, 4'b0001);
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 1); cyc("t3.ack2");

        // T4: forwarding of Z written in the same cycle as the request
        drive(1, 4'd3, 4'b0000, 0, 4'd0, 0); cyc("t4.clrz");
        drive(1, 4'd3, 4'b0100, 1, 4'd1, 0); cyc("t4.fwd");
        chk("t4.fwd_taken", {3'b0, taken}, 4'b0001);
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 1); cyc("t4.ack");

        // T5: hold without Ack, flags change underneath, then back-to-back
        drive(0, 4'd0, 4'b0000, 1, 4'd6, 0); cyc("t5.h1");
        drive(1, 4'd3, 4'b1000, 1, 4'd6, 0); cyc("t5.h2");
        chk("t5.stable_taken", {2'b0, busy, taken}, 4'b0010);
        drive(0, 4'd0, 4'b0000, 1, 4'd6, 0); cyc("t5.h3");
        chk("t5.busy_held", {2'b0, busy, taken}, 4'b0010);
        drive(0, 4'd0, 4'b0000, 1, 4'd8, 1); cyc("t5.b2b");
        chk("t5.b2b_ba", {2'b0, valid, taken}, 4'b0011);
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 1); cyc("t5.ack");
        chk("t5.released", {3'b0, valid}, 4'b0000);

        // T6: unsupported condition codes
        drive(0, 4'd0, 4'b0000, 1, 4'd15, 0); cyc("t6.ill");
        chk("t6.illegal", {1'b0, valid, taken, illegal}, 4'b0101);
        drive(0, 4'd0, 4'b0000, 1, 4'd2, 1); cyc("t6.ill2");
        drive(0, 4'd0, 4'b0000, 1, 4'd0, 1); cyc("t6.bn");
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 1); cyc("t6.ack");

        // Unsupported ALU selection leaves flags untouched
        drive(1, 4'd9, 4'b1111, 0, 4'd0, 0); cyc("sel.hold");

        // T1: reset mid-VALID takes effect without a clock edge
        drive(1, 4'd3, 4'b1111, 1, 4'd8, 0); cyc("t1.pre");
        drive(0, 4'd0, 4'b0000, 1, 4'd8, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1.flags", flags, 4'b0000);
        chk("t1.outs", {valid, taken, illegal, busy}, 4'b0000);
        mflags = 4'b0000;
        mvalid = 1'b0;
        sb.delete();
        drive(0, 4'd0, 4'b0000, 0, 4'd0, 0);
        #3 rst_n = 1'b1;
        cyc("t1.post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
